// File: rtl/ps2_keycount.sv
// PS/2 keyboard receiver and make-code counter, clk25 domain.
// Raw PS/2 lines are synchronized, the clock is glitch-filtered, and frames
// are decoded on filtered falling edges. Good bytes update scancode and the
// key-press count; bad frames only pulse frame_err.
// Optional build macro PS2_TIMEOUT_EN: adds an inter-edge timeout that aborts
// a stalled frame with a frame_err pulse.
//
// state  | meaning
// IDLE   | waiting for a start bit (fall with data low)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | capturing the odd-parity bit
// STOP   | checking stop bit and parity, then reporting the byte
module ps2_keycount #(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 25000
) (
  input  logic       clk25,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scancode,
  output logic       code_valid,
  output logic       frame_err,
  output logic [7:0] kcount
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_s1, clk_s2, dat_s1, dat_s2;
  logic          filt, fall;
  logic [FW-1:0] fcnt;
  state_t        state_q, state_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          good, bad;
  logic          brk_q;

  // Two-stage synchronizers; lines idle high.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk;
      clk_s2 <= clk_s1;
      dat_s1 <= ps2_data;
      dat_s2 <= dat_s1;
    end
  end

  // Glitch filter: level flips after FILT_LEN consecutive differing samples.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      filt <= 1'b1;
      fcnt <= '0;
      fall <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 != filt) begin
        if (fcnt == FW'(FILT_LEN - 1)) begin
          filt <= clk_s2;
          fcnt <= '0;
          fall <= ~clk_s2;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else begin
        fcnt <= '0;
      end
    end
  end

`ifdef PS2_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  // Inter-edge timer: cleared on every fall and while idle.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst)
      tcnt <= '0;
    else if (state_q == IDLE || fall)
      tcnt <= '0;
    else
      tcnt <= tcnt + 1'b1;
  end
`endif

  // Frame state and shift registers.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      bidx_q  <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
    end
  end

  // Next-state decode and good/bad frame classification.
  always_comb begin
    state_d = state_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    par_d   = par_q;
    good    = 1'b0;
    bad     = 1'b0;
    case (state_q)
      IDLE: if (fall && !dat_s2) begin
        state_d = DATA;
        bidx_d  = '0;
      end
      DATA: if (fall) begin
        shift_d = {dat_s2, shift_q[7:1]};
        bidx_d  = bidx_q + 1'b1;
        if (bidx_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fall) begin
        par_d   = dat_s2;
        state_d = STOP;
      end
      STOP: if (fall) begin
        state_d = IDLE;
        if (dat_s2 && (^{shift_q, par_q})) good = 1'b1;
        else                               bad  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
`ifdef PS2_TIMEOUT_EN
    if (state_q != IDLE && !fall && tcnt == TW'(TIMEOUT - 1)) begin
      state_d = IDLE;
      bad     = 1'b1;
    end
`endif
  end

  // Outputs and make-code counting with break-prefix tracking.
  always_ff @(posedge clk25 or negedge rst) begin
    if (!rst) begin
      scancode   <= 8'h00;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      kcount     <= 8'h00;
      brk_q      <= 1'b0;
    end else begin
      code_valid <= good;
      frame_err  <= bad;
      if (good) begin
        scancode <= shift_q;
        if (shift_q == 8'hE0) begin
          brk_q <= brk_q;
        end else if (shift_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else if (brk_q) begin
          brk_q <= 1'b0;
        end else begin
          kcount <= kcount + 8'd1;
        end
      end
    end
  end

endmodule
